serial_subtractor: RTL and testbench

- Bit-serial two's-complement subtractor computing diff = a - b, LSB first, one bit per clock.
- Uses a single full-subtractor cell: difference = x ^ y ^ bin; borrow = (~x & y) | (~(x ^ y) & bin).
- Area-lean inverse of the team's full adder; it is the companion arithmetic block for serial datapaths.
- Start/done handshake with operand capture; the result is held until the next start.

---
 rtl/serial_subtractor.sv | 97 +++++++++
 tb/tb_serial_subtractor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor diff = a - b, LSB first, one full-subtractor cell, start/done handshake.
// Optional SERIAL_SUB_OVF_EN adds a registered signed-overflow flag (ovf).
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic             x;
  logic             y;
  logic             d;
  logic             br_nxt;
  logic             last;
  logic [WIDTH-1:0] res_nxt;

  assign x       = a_sr[0];
  assign y       = b_sr[0];
  assign d       = x ^ y ^ br;
  assign br_nxt  = (~x & y) | (~(x ^ y) & br);
  // res_sr keeps only the upper WIDTH-1 result bits; the newest bit completes the word.
  assign res_nxt = {d, res_sr};
  assign last    = (cnt == CNT_W'(WIDTH - 1));

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= 1'b0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          res_sr <= res_nxt[WIDTH-1:1];
          br     <= br_nxt;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last) begin
            state      <= DONE;
            diff       <= res_nxt;
            borrow_out <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
            // On the last bit x and y are the operand sign bits and d is the result sign.
            ovf        <= (x != y) && (d != x);
`endif
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: arithmetic reference model checked every cycle plus directed literals.
module tb_serial_subtractor;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: cycles remaining in the operation and the arithmetic result it will publish.
  int               m_left = 0;
  logic             m_done = 1'b0;
  logic [WIDTH-1:0] m_diff = '0;
  logic             m_brw  = 1'b0;
  logic             m_ovf  = 1'b0;
  logic [WIDTH-1:0] p_diff = '0;
  logic             p_brw  = 1'b0;
  logic             p_ovf  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_diff = '0;
      m_brw  = 1'b0;
      m_ovf  = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_diff = p_diff;
        m_brw  = p_brw;
        m_ovf  = p_ovf;
      end
    end else if (start) begin
      p_diff = a - b;
      p_brw  = (a < b);
      p_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (p_diff[WIDTH-1] != a[WIDTH-1]);
      m_left = WIDTH;
    end
  end

  int cyc = 0;
  int last_done_cyc = 0;
  bit in_regress = 1'b0;

  always @(negedge clk) begin
    cyc++;
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("done", 32'(done), 32'(m_done));
    chk("diff", 32'(diff), 32'(m_diff));
    chk("borrow_out", 32'(borrow_out), 32'(m_brw));
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
    if (done) begin
      if (in_regress && last_done_cyc > 0)
        chk("done_spacing", 32'(cyc - last_done_cyc), 32'(WIDTH + 2));
      last_done_cyc = cyc;
    end
  end

  task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                       input logic [WIDTH-1:0] ed, input logic eb, input logic eo,
                       input bit ign, input string nm);
    int n;
    @(negedge clk);
    a = ta;
    b = tb_v;
    start = 1'b1;
    @(posedge clk);
    n = 1;
    #1;
    start = 1'b0;
    a = ~ta;
    b = ~tb_v;
    while (!done && n < 4 * WIDTH) begin
      @(posedge clk);
      n++;
      #1;
      if (ign && n == 4) begin
        start = 1'b1;
        a = 8'h11;
        b = 8'h22;
      end else begin
        start = 1'b0;
      end
    end
    chk({nm, "_done_seen"}, 32'(done), 32'd1);
    chk({nm, "_latency"}, 32'(n), 32'(WIDTH + 1));
    chk({nm, "_diff"}, 32'(diff), 32'(ed));
    chk({nm, "_borrow"}, 32'(borrow_out), 32'(eb));
    chk({nm, "_model_diff"}, 32'(m_diff), 32'(ed));
`ifdef SERIAL_SUB_OVF_EN
    chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo) chk({nm, "_model_ovf"}, 32'(m_ovf), 32'(eo));
`endif
    @(posedge clk);
    #1;
    chk({nm, "_done_one_cycle"}, 32'(done), 32'd0);
    chk({nm, "_diff_held"}, 32'(diff), 32'(ed));
  endtask

  initial begin
    int ndone;
    int guard;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow_out), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op(8'h50, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0, "sub_50_20");
    do_op(8'h20, 8'h50, 8'hD0, 1'b1, 1'b0, 1'b0, "sub_20_50");
    do_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0, "wrap_00_01");
    do_op(8'h3C, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b1, "equal_ignore");
    repeat (5) @(negedge clk);
    chk("ignored_start_diff", 32'(diff), 32'h00);
    do_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, "ovf_80_01");

    // Abort mid-operation with an asynchronous reset.
    @(negedge clk);
    a = 8'hFF;
    b = 8'h01;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("pre_abort_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_borrow", 32'(borrow_out), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) begin
      @(negedge clk);
      chk("no_done_after_abort", 32'(done), 32'd0);
    end
    do_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0, "after_abort");

    // Back-to-back regression with start held high and operands changing every cycle.
    in_regress = 1'b1;
    last_done_cyc = 0;
    ndone = 0;
    guard = 0;
    while (ndone < 1000 && guard < 1000 * (WIDTH + 2) + 100) begin
      @(negedge clk);
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      start = 1'b1;
      if (done) ndone++;
      guard++;
    end
    chk("regress_done_count", 32'(ndone), 32'd1000);
    start = 1'b0;
    in_regress = 1'b0;
    repeat (WIDTH + 4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
